final_syst: RTL and testbench
=============================

# final_syst

Serial frame extractor. It watches a 1-bit input stream for the flag `111110`, then reads a 3-bit length header N (MSB first). It then passes exactly 8·(N+1) payload bits straight through to `serout`, and returns to flag hunting. Its internal counters, shift register and state are exported as observation ports for system-level debug.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock; all registers update on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `serin` input 1: serial data, sampled on each rising edge.
- `serout` output 1: payload pass-through; 0 outside payload.
- `co3` output 1: header counter terminal count.
- `detect` output 1: flag detected this cycle.
- `co8` output 1: byte boundary within payload.
- `inputcounter8` output 8: payload bit counter.
- `ntcout` output 3: bytes remaining after the current byte.
- `shift` output 8: last 8 sampled input bits.
- `state` output 3: FSM state code.

## Operation
- **Shift register:** every edge, in every state, `shift` <= {shift[6:0], serin}.
- **States:** IDLE=0, HDR=1, XMIT=2, DONE=3. Codes 4–7 go to IDLE on the next edge.
- **IDLE:**
  - `detect` is combinational: `detect` = (state==IDLE) && ({shift[4:0],serin} == 6'b111110).
  - On an edge with `detect`=1: go to HDR, clear the internal 2-bit header counter cnt3, and clear `inputcounter8`.
- **HDR:**
  - cnt3 increments on each edge.
  - `co3` = (state==HDR) && (cnt3==2).
  - On an edge with `co3`=1: `ntcout` <= {shift[1:0], serin}, and go to XMIT.
- **XMIT:**
  - `serout` = `serin` (combinational).
  - `inputcounter8` increments on each edge.
  - `co8` = (state==XMIT) && (inputcounter8[2:0]==7).
  - On an edge with `co8`=1: if `ntcout`==0, go to DONE; otherwise `ntcout` <= ntcout−1.
- **DONE:** lasts one cycle, `serout`=0, then IDLE.
- Flag bits inside a payload are ignored; detection runs only in IDLE.
- `serout`=0 in every state except XMIT.

## Timing
- **Reset values:** `state`=IDLE, `shift`=0, `ntcout`=0, `inputcounter8`=0, cnt3=0. Therefore `serout`, `co3`, `co8` and `detect` are all 0.
- Reset asserted mid-frame aborts the frame immediately.
- **Header:** exactly 3 edges after the flag edge. The first payload bit is sampled on the edge after the `co3` edge.
- **Payload:** exactly 8·(N+1) cycles of XMIT, with zero latency from `serin` to `serout`.
  - `inputcounter8` peaks at 8·(N+1)−1 (max 63); 8 bits never wraps.
- **Back-to-back frames:** the earliest next flag completion is the edge after DONE, so there is a minimum of one idle cycle between frames.

## Configuration
- `FINALSYST_SHIFT_CLR_EN`:
  - **Defined:** `shift` is cleared to 0 on the DONE→IDLE edge, so payload tail bits cannot combine with new bits into a false flag. The bit sampled on that edge is lost.
  - **Undefined:** `shift` keeps shifting continuously, as described in Operation.

## Structure
- Package `final_syst_pkg`:
  - state enum (IDLE/HDR/XMIT/DONE, 3-bit)
  - FLAG constant 6'b111110
  - header width 3
  - byte width 8
- One natural sub-module `flag_detector`: the shift register plus the combinational match, producing `shift` and the raw match. The top module gates the raw match with state==IDLE.

## Test plan
- **Reset:** assert `rst` mid-frame → all outputs immediately 0, `state`=0. Deassert with `serin`=0 → stays in IDLE.
- **Flag plus N=7:** drive `0111110` then `111`.
  - `detect`=1 during the cycle the final 0 is present.
  - `co3`=1 during the third header bit.
  - `ntcout`=7 on entering XMIT.
  - Then 64 payload bits are mirrored on `serout`.
  - `co8` pulses 8 times; `inputcounter8` reaches 63; then DONE, then IDLE.
- **N=0:** flag, `000`, payload 0xA5 → `serout`=`10100101` for 8 cycles, a single `co8`, `serout`=0 afterwards.
- **Flag inside payload:** flag, `000`, payload `01111100` → no `detect` during XMIT, frame length unaffected.
- **Near-miss patterns:** stream `0111111110`, then `11110` → `detect` fires only on the first exact `111110` suffix, and never on the trailing `11110`.
- **Macro check:** with `FINALSYST_SHIFT_CLR_EN` defined, `shift`=0 on the first IDLE cycle after DONE. Undefined, `shift` holds the last 8 sampled bits.

Source files
------------

// File: rtl/final_syst_pkg.sv
// Shared types and constants for the final_syst serial frame extractor.
// Build option: FINALSYST_SHIFT_CLR_EN clears the flag shifter when a frame ends.
package final_syst_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        XMIT = 3'd2,
        DONE = 3'd3
    } state_e;

    localparam int         FLAG_W = 6;
    localparam logic [5:0] FLAG   = 6'b111110;
    localparam int         HDR_W  = 3;
    localparam int         BYTE_W = 8;

endpackage

// File: rtl/final_syst_flag_detector.sv
// Input shift register and raw flag matcher for final_syst.
// The match looks at the five newest stored bits plus the live input bit.
module flag_detector
    import final_syst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              serin_i,
    input  logic              clr_i,
    output logic [BYTE_W-1:0] shift_o,
    output logic              match_o
);

    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] shift_d;

    always_comb begin
        shift_d = {shift_q[BYTE_W-2:0], serin_i};
        if (clr_i) begin
            shift_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign shift_o = shift_q;
    assign match_o = ({shift_q[FLAG_W-2:0], serin_i} == FLAG);

endmodule

// File: rtl/final_syst.sv
// Serial frame extractor: flag hunt, 3-bit length header, 8*(N+1)-bit payload.
// Build option: FINALSYST_SHIFT_CLR_EN clears the shifter on DONE->IDLE.
module final_syst
    import final_syst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              serin,
    output logic              serout,
    output logic              co3,
    output logic              detect,
    output logic              co8,
    output logic [7:0]        inputcounter8,
    output logic [HDR_W-1:0]  ntcout,
    output logic [BYTE_W-1:0] shift,
    output logic [2:0]        state
);

    logic [2:0]       state_q, state_d;
    logic [1:0]       cnt3_q, cnt3_d;
    logic [7:0]       ic8_q, ic8_d;
    logic [HDR_W-1:0] ntc_q, ntc_d;
    logic             match;
    logic             shift_clr;

`ifdef FINALSYST_SHIFT_CLR_EN
    assign shift_clr = (state_q == DONE);
`else
    assign shift_clr = 1'b0;
`endif

    flag_detector u_flag_detector (
        .clk     (clk),
        .rst     (rst),
        .serin_i (serin),
        .clr_i   (shift_clr),
        .shift_o (shift),
        .match_o (match)
    );

    assign detect = (state_q == IDLE) && match;
    assign co3    = (state_q == HDR) && (cnt3_q == 2'd2);
    assign co8    = (state_q == XMIT) && (ic8_q[2:0] == 3'd7);
    assign serout = (state_q == XMIT) && serin;

    always_comb begin
        state_d = state_q;
        cnt3_d  = cnt3_q;
        ic8_d   = ic8_q;
        ntc_d   = ntc_q;
        case (state_q)
            IDLE: begin
                if (detect) begin
                    state_d = HDR;
                    cnt3_d  = 2'd0;
                    ic8_d   = 8'd0;
                end
            end
            HDR: begin
                cnt3_d = cnt3_q + 2'd1;
                if (co3) begin
                    ntc_d   = {shift[1:0], serin};
                    state_d = XMIT;
                end
            end
            XMIT: begin
                ic8_d = ic8_q + 8'd1;
                if (co8) begin
                    if (ntc_q == '0) begin
                        state_d = DONE;
                    end else begin
                        ntc_d = ntc_q - 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt3_q  <= 2'd0;
            ic8_q   <= 8'd0;
            ntc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt3_q  <= cnt3_d;
            ic8_q   <= ic8_d;
            ntc_q   <= ntc_d;
        end
    end

    assign inputcounter8 = ic8_q;
    assign ntcout        = ntc_q;
    assign state         = state_q;

endmodule

// File: tb/tb_final_syst.sv
// Directed vector bench for final_syst.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_final_syst;

    logic       clk;
    logic       rst;
    logic       serin;
    logic       serout;
    logic       co3;
    logic       detect;
    logic       co8;
    logic [7:0] inputcounter8;
    logic [2:0] ntcout;
    logic [7:0] shift;
    logic [2:0] state;

    final_syst dut (
        .clk           (clk),
        .rst           (rst),
        .serin         (serin),
        .serout        (serout),
        .co3           (co3),
        .detect        (detect),
        .co8           (co8),
        .inputcounter8 (inputcounter8),
        .ntcout        (ntcout),
        .shift         (shift),
        .state         (state)
    );

`ifdef FINALSYST_SHIFT_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    typedef struct {
        bit       s;
        bit       det;
        bit       c3;
        bit       c8;
        bit       so;
        bit [2:0] st;
    } vec_t;

    vec_t     tbl[$];
    int       nvec  = 0;
    int       nmiss = 0;
    bit [7:0] hist  = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit b);
        @(negedge clk);
        serin = b;
        #1;
    endtask

    // Reference copy of the 8-bit sampled-input history.
    task automatic upd(input bit clr);
        if (CLR_EN && clr) hist = 8'h00;
        else hist = {hist[6:0], serin};
    endtask

    task automatic add(input bit s, input bit d, input bit c3,
                       input bit c8, input bit so, input bit [2:0] st);
        vec_t v;
        v.s = s; v.det = d; v.c3 = c3;
        v.c8 = c8; v.so = so; v.st = st;
        tbl.push_back(v);
    endtask

    task automatic add_seq(input bit [63:0] bits, input int n,
                           input bit [2:0] st, input int det_at,
                           input int c3_at, input bit pay);
        for (int k = 0; k < n; k++) begin
            bit b;
            b = bits[n-1-k];
            add(b, k == det_at, k == c3_at, pay && (k % 8 == 7),
                pay && b, st);
        end
    endtask

    initial begin
        int c8n;
        rst   = 1'b1;
        serin = 1'b0;
        #12;
        chk("reset_state",
            {serout, co3, co8, detect, inputcounter8, ntcout, shift, state},
            32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Near miss: 11110 must not fire.
        add_seq(64'b011110, 6, 3'd0, -1, -1, 1'b0);
        // Frame N=0, payload A5.
        add_seq(64'b0111110, 7, 3'd0, 6, -1, 1'b0);
        add_seq(64'b000, 3, 3'd1, -1, 2, 1'b0);
        add_seq(64'hA5, 8, 3'd2, -1, -1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        // Frame N=0 carrying a flag pattern in its payload.
        add_seq(64'b0111110, 7, 3'd0, 6, -1, 1'b0);
        add_seq(64'b000, 3, 3'd1, -1, 2, 1'b0);
        add_seq(64'b01111100, 8, 3'd2, -1, -1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        // Long run of ones: fires only on the final 0, then header 111.
        add_seq(64'b0111111110, 10, 3'd0, 9, -1, 1'b0);
        add_seq(64'b111, 3, 3'd1, -1, 2, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].s);
            chk($sformatf("vec%0d", i),
                {detect, co3, co8, serout, state, shift},
                {tbl[i].det, tbl[i].c3, tbl[i].c8, tbl[i].so,
                 tbl[i].st, hist});
            upd(tbl[i].st == 3'd3);
        end

        // N=7 payload: 64 random bits mirrored.
        c8n = 0;
        for (int i = 0; i < 64; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            drive(b);
            chk($sformatf("pay%0d", i),
                {serout, co8, state, ntcout, inputcounter8},
                {b, (i % 8 == 7), 3'd2, 3'(7 - i / 8), 8'(i)});
            if (co8) c8n++;
            upd(1'b0);
        end
        chk("co8_count", c8n, 8);
        drive(1'b1);
        chk("done", {state, serout, detect, co8}, {3'd3, 3'b000});
        upd(1'b1);
        drive(1'b0);
        chk("idle_shift", {state, shift}, {3'd0, hist});
        upd(1'b0);

        // Frame N=2 aborted by reset inside the payload.
        for (int k = 0; k < 7; k++) begin
            drive(k != 0 && k != 6);
            upd(1'b0);
        end
        drive(1'b0); upd(1'b0);
        drive(1'b1); upd(1'b0);
        drive(1'b0); upd(1'b0);
        drive(1'b1);
        chk("n2_enter", {state, ntcout, inputcounter8}, {3'd2, 3'd2, 8'd0});
        upd(1'b0);
        drive(1'b1);
        rst = 1'b1;
        #1;
        chk("reset_abort",
            {serout, co3, co8, detect, inputcounter8, ntcout, shift, state},
            32'h0);
        @(negedge clk);
        rst   = 1'b0;
        serin = 1'b0;
        hist  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0);
            chk($sformatf("post_rst%0d", k), {state, detect, shift},
                {3'd0, 1'b0, hist});
            upd(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
